// File: rtl/seg7_display_sched.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_sched
// Purpose  : Shares a 4-digit multiplexed 7-segment display between two
//            valid/ready sources. Generates digit-scan and frame timing,
//            arbitrates ownership with a minimum hold, swaps the shown value
//            only at frame boundaries and drives the (blinking) colon enable.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_display_sched #(
   parameter int SCAN_DIV     = 1000,
   parameter int HOLD_FRAMES  = 250,
   parameter int BLINK_FRAMES = 125
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        src0_valid_i,
   input  logic [15:0] src0_number_i,
   input  logic [1:0]  src0_colon_i,
   output logic        src0_ready_o,
   input  logic        src1_valid_i,
   input  logic [15:0] src1_number_i,
   input  logic [1:0]  src1_colon_i,
   output logic        src1_ready_o,
   output logic [15:0] number_o,
   output logic        colon_en_o,
   output logic        scan_tick_o,
   output logic        frame_tick_o,
   output logic        owner_o,
   output logic        owner_valid_o
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   localparam logic [1:0] COLON_ON    = 2'b01;
   localparam logic [1:0] COLON_BLINK = 2'b10;

   logic [PW-1:0] presc_q,     presc_d;
   logic [1:0]    phase_q,     phase_d;
   logic [HW-1:0] hold_q,      hold_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_ph_q,  blink_ph_d;
   logic          rr_q,        rr_d;
   logic [15:0]   number_q,    number_d;
   logic [1:0]    mode_q,      mode_d;
   logic          colon_en_q,  colon_en_d;
   logic          owner_q,     owner_d;
   logic          owner_vld_q, owner_vld_d;

   logic scan_tick;
   logic frame_tick;
   logic hold_lock;
   logic req0;
   logic req1;
   logic winner;
   logic xfer;

   // Timing pulses and arbitration; the ready handshake is combinational so
   // a source sees acceptance in the very frame_tick cycle it is granted.
   always_comb begin
      scan_tick  = (presc_q == PW'(SCAN_DIV - 1));
      frame_tick = scan_tick && (phase_q == 2'd3);
      // While the hold is still running only the current owner may update;
      // at hold_q == 1 the final frame of the hold is ending, so the other
      // source may already take over at this frame_tick.
      hold_lock  = owner_vld_q && (hold_q > HW'(1));
      req0       = src0_valid_i && (!hold_lock || (owner_q == 1'b0));
      req1       = src1_valid_i && (!hold_lock || (owner_q == 1'b1));
      // Round-robin pointer only breaks ties between two eligible requests.
      winner     = (req0 && req1) ? rr_q : req1;
      xfer       = frame_tick && (req0 || req1);
   end

   // Next-state for counters, captured display value and colon enable.
   always_comb begin
      presc_d     = scan_tick ? '0 : presc_q + PW'(1);
      phase_d     = scan_tick ? phase_q + 2'd1 : phase_q;

      hold_d      = hold_q;
      rr_d        = rr_q;
      number_d    = number_q;
      mode_d      = mode_q;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
      if (xfer) begin
         hold_d      = HW'(HOLD_FRAMES);
         rr_d        = ~winner;
         number_d    = winner ? src1_number_i : src0_number_i;
         mode_d      = winner ? src1_colon_i  : src0_colon_i;
         owner_d     = winner;
         owner_vld_d = 1'b1;
      end else if (frame_tick && (hold_q != '0)) begin
         hold_d = hold_q - HW'(1);
      end

      // Blink timebase runs free of grants, stepping once per frame.
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
      if (frame_tick) begin
         if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end

      // Decoded from next-state values so the colon changes together with
      // the number, one cycle after the frame_tick.
      colon_en_d = (mode_d == COLON_ON) || ((mode_d == COLON_BLINK) && blink_ph_d);
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         phase_q     <= '0;
         hold_q      <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         rr_q        <= 1'b0;
         number_q    <= '0;
         mode_q      <= '0;
         colon_en_q  <= 1'b0;
         owner_q     <= 1'b0;
         owner_vld_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         phase_q     <= phase_d;
         hold_q      <= hold_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         rr_q        <= rr_d;
         number_q    <= number_d;
         mode_q      <= mode_d;
         colon_en_q  <= colon_en_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
      end
   end

   assign src0_ready_o  = xfer && (winner == 1'b0);
   assign src1_ready_o  = xfer && (winner == 1'b1);
   assign number_o      = number_q;
   assign colon_en_o    = colon_en_q;
   assign scan_tick_o   = scan_tick;
   assign frame_tick_o  = frame_tick;
   assign owner_o       = owner_q;
   assign owner_valid_o = owner_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_display_sched
// Purpose  : Directed self-checking bench for seg7_display_sched with
//            SCAN_DIV=4, HOLD_FRAMES=2, BLINK_FRAMES=2. Cycle 1 is the clock
//            period right after reset release; scan_tick lands in cycles
//            4,8,..., frame_tick in cycles 16,32,...
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_display_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        src0_valid_i = 1'b0;
   logic [15:0] src0_number_i = '0;
   logic [1:0]  src0_colon_i = '0;
   logic        src0_ready_o;
   logic        src1_valid_i = 1'b0;
   logic [15:0] src1_number_i = '0;
   logic [1:0]  src1_colon_i = '0;
   logic        src1_ready_o;
   logic [15:0] number_o;
   logic        colon_en_o;
   logic        scan_tick_o;
   logic        frame_tick_o;
   logic        owner_o;
   logic        owner_valid_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   seg7_display_sched #(
      .SCAN_DIV     (4),
      .HOLD_FRAMES  (2),
      .BLINK_FRAMES (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .src0_valid_i  (src0_valid_i),
      .src0_number_i (src0_number_i),
      .src0_colon_i  (src0_colon_i),
      .src0_ready_o  (src0_ready_o),
      .src1_valid_i  (src1_valid_i),
      .src1_number_i (src1_number_i),
      .src1_colon_i  (src1_colon_i),
      .src1_ready_o  (src1_ready_o),
      .number_o      (number_o),
      .colon_en_o    (colon_en_o),
      .scan_tick_o   (scan_tick_o),
      .frame_tick_o  (frame_tick_o),
      .owner_o       (owner_o),
      .owner_valid_o (owner_valid_o)
   );

   always #5 clk = ~clk;

   // Advance to the next cycle; sampling happens just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reset with idle sources; release on a falling edge so cycle 1 starts.
   task automatic apply_reset();
      rst_n        = 1'b0;
      src0_valid_i = 1'b0; src0_number_i = '0; src0_colon_i = '0;
      src1_valid_i = 1'b0; src1_number_i = '0; src1_colon_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if ({number_o, colon_en_o, scan_tick_o, frame_tick_o, owner_o, owner_valid_o,
           src0_ready_o, src1_ready_o} !== 23'd0) begin
         errors++;
         $display("FAIL reset_state: got num=%h colon=%b scan=%b frame=%b own=%b ov=%b rdy=%b%b, want all 0",
                  number_o, colon_en_o, scan_tick_o, frame_tick_o, owner_o, owner_valid_o,
                  src0_ready_o, src1_ready_o);
      end
   endtask

   task automatic test_timing();
      apply_reset();
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) tick();
         #1;
         checks++;
         if (scan_tick_o !== ((cyc % 4) == 0) || frame_tick_o !== ((cyc % 16) == 0)) begin
            errors++;
            $display("FAIL timing_ticks cyc=%0d: got scan=%b frame=%b, want scan=%b frame=%b",
                     cyc, scan_tick_o, frame_tick_o, (cyc % 4) == 0, (cyc % 16) == 0);
         end
         checks++;
         if (number_o !== 16'h0000 || src0_ready_o !== 1'b0 || src1_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL timing_idle cyc=%0d: got num=%h rdy=%b%b, want 0000 and 00",
                     cyc, number_o, src0_ready_o, src1_ready_o);
         end
      end
   endtask

   task automatic test_single_source();
      apply_reset();
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) tick();
         if (cyc == 5) begin
            src0_valid_i = 1'b1; src0_number_i = 16'h1234; src0_colon_i = 2'b01;
         end
         if (cyc == 17) src0_valid_i = 1'b0;
         #1;
         checks++;
         if (src0_ready_o !== (cyc == 16) || src1_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ready cyc=%0d: got rdy0=%b rdy1=%b, want rdy0=%b rdy1=0",
                     cyc, src0_ready_o, src1_ready_o, cyc == 16);
         end
         checks++;
         if (number_o !== ((cyc >= 17) ? 16'h1234 : 16'h0000) || colon_en_o !== (cyc >= 17)) begin
            errors++;
            $display("FAIL single_value cyc=%0d: got num=%h colon=%b, want num=%h colon=%b",
                     cyc, number_o, colon_en_o, (cyc >= 17) ? 16'h1234 : 16'h0000, cyc >= 17);
         end
         checks++;
         if (owner_o !== 1'b0 || owner_valid_o !== (cyc >= 17)) begin
            errors++;
            $display("FAIL single_owner cyc=%0d: got own=%b ov=%b, want own=0 ov=%b",
                     cyc, owner_o, owner_valid_o, cyc >= 17);
         end
      end
   endtask

   // Contention at frame 16, hold blocks src1 at 32, src1 wins at 48,
   // owner update at 64 reloads the hold, src0 blocked at 80, wins at 96.
   task automatic test_contention_hold();
      logic [15:0] exp_num;
      logic        exp_own;
      apply_reset();
      for (int c = 1; c <= 100; c++) begin
         if (c > 1) tick();
         case (cyc)
            1: begin
               src0_valid_i = 1'b1; src0_number_i = 16'h1111; src0_colon_i = 2'b00;
               src1_valid_i = 1'b1; src1_number_i = 16'h2222; src1_colon_i = 2'b00;
            end
            17: src0_valid_i = 1'b0;
            49: begin
               src1_number_i = 16'hBEEF;
               src0_valid_i  = 1'b1; src0_number_i = 16'h3333;
            end
            65: src1_valid_i = 1'b0;
            97: src0_valid_i = 1'b0;
            default: ;
         endcase
         #1;
         checks++;
         if (src0_ready_o !== (cyc == 16 || cyc == 96) ||
             src1_ready_o !== (cyc == 48 || cyc == 64)) begin
            errors++;
            $display("FAIL contention_ready cyc=%0d: got rdy0=%b rdy1=%b, want rdy0=%b rdy1=%b",
                     cyc, src0_ready_o, src1_ready_o, cyc == 16 || cyc == 96, cyc == 48 || cyc == 64);
         end
         if      (cyc <= 16) exp_num = 16'h0000;
         else if (cyc <= 48) exp_num = 16'h1111;
         else if (cyc <= 64) exp_num = 16'h2222;
         else if (cyc <= 96) exp_num = 16'hBEEF;
         else                exp_num = 16'h3333;
         exp_own = (cyc >= 49 && cyc <= 96);
         checks++;
         if (number_o !== exp_num || owner_o !== exp_own || owner_valid_o !== (cyc >= 17)) begin
            errors++;
            $display("FAIL contention_state cyc=%0d: got num=%h own=%b ov=%b, want num=%h own=%b ov=%b",
                     cyc, number_o, owner_o, owner_valid_o, exp_num, exp_own, cyc >= 17);
         end
      end
   endtask

   // Blink mode: colon_en high in cycles 33..64, low 65..96, high from 97.
   task automatic test_blink();
      logic exp_col;
      apply_reset();
      for (int c = 1; c <= 100; c++) begin
         if (c > 1) tick();
         if (cyc == 1) begin
            src0_valid_i = 1'b1; src0_number_i = 16'hABCD; src0_colon_i = 2'b10;
         end
         if (cyc == 17) src0_valid_i = 1'b0;
         #1;
         exp_col = (((cyc - 1) / 32) % 2) == 1;
         checks++;
         if (colon_en_o !== exp_col) begin
            errors++;
            $display("FAIL blink_colon cyc=%0d: got %b, want %b", cyc, colon_en_o, exp_col);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int c = 1; c <= 48; c++) begin
         if (c > 1) tick();
         if (cyc == 1) begin
            src0_valid_i = 1'b1; src0_number_i = 16'h5555; src0_colon_i = 2'b01;
         end
         if (cyc == 17) begin
            src0_valid_i = 1'b0;
            src1_valid_i = 1'b1; src1_number_i = 16'h6666; src1_colon_i = 2'b00;
         end
         #1;
         checks++;
         if (src1_ready_o !== (cyc == 48)) begin
            errors++;
            $display("FAIL arst_prehold cyc=%0d: got rdy1=%b, want %b", cyc, src1_ready_o, cyc == 48);
         end
      end
      checks++;
      if (number_o !== 16'h5555 || colon_en_o !== 1'b1 || owner_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL arst_before: got num=%h colon=%b ov=%b, want 5555 1 1",
                  number_o, colon_en_o, owner_valid_o);
      end
      // Reset lands between clock edges.
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (number_o !== 16'h0000 || owner_valid_o !== 1'b0 || colon_en_o !== 1'b0 ||
          src0_ready_o !== 1'b0 || src1_ready_o !== 1'b0 || frame_tick_o !== 1'b0) begin
         errors++;
         $display("FAIL arst_immediate: got num=%h ov=%b colon=%b rdy=%b%b frame=%b, want all 0",
                  number_o, owner_valid_o, colon_en_o, src0_ready_o, src1_ready_o, frame_tick_o);
      end
      src1_valid_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 1;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) tick();
         #1;
         checks++;
         if (scan_tick_o !== ((cyc % 4) == 0) || frame_tick_o !== (cyc == 16) ||
             number_o !== 16'h0000) begin
            errors++;
            $display("FAIL arst_restart cyc=%0d: got scan=%b frame=%b num=%h, want scan=%b frame=%b num=0000",
                     cyc, scan_tick_o, frame_tick_o, number_o, (cyc % 4) == 0, cyc == 16);
         end
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_single_source();
      test_contention_hold();
      test_blink();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_display_sched.md
Name: seg7_display_sched

Overview:
- Scheduler that shares the 4-digit multiplexed 7-segment display between two requesters.
- Generates the digit-scan and frame timing the display driver steps on.
- Arbitrates display ownership with valid/ready handshakes and a minimum-hold rule.
- Updates only at frame boundaries, so the display never tears, and produces the (optionally blinking) colon enable.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit step (scan_tick period); legal >= 2.
- HOLD_FRAMES, 250: minimum full frames a granted source keeps the display before the other source may take it; legal >= 1.
- BLINK_FRAMES, 125: frames per colon blink half-period; legal >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- src0_valid  input  1  source 0 has a value to show.
- src0_number  input  16  source 0 display value.
- src0_colon  input  2  source 0 colon mode: 00 off, 01 on, 10 blink, 11 treated as off.
- src0_ready  output  1  source 0 transfer accepted this cycle.
- src1_valid, src1_number, src1_colon, src1_ready  same as source 0, for source 1.
- number  output  16  value to the display driver.
- colon_en  output  1  colon enable to the display driver.
- scan_tick  output  1  one-cycle pulse; the driver advances its active digit.
- frame_tick  output  1  one-cycle pulse at the end of digit 3.
- owner  output  1  index of the last granted source.
- owner_valid  output  1  a grant has occurred since reset.

Behaviour:
- Reset (async, immediate, also mid-operation) clears all state and outputs:
  - prescaler, digit phase, hold_cnt, blink_cnt, blink phase, RR pointer: 0.
  - number = 0, colon mode = 00, colon_en = 0, ticks 0, readies 0, owner 0, owner_valid 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - scan_tick = 1 in the cycle the count == SCAN_DIV-1. The first pulse is SCAN_DIV cycles after reset release.
- Digit phase:
  - 2-bit counter, incremented on scan_tick, wraps 3 -> 0.
  - frame_tick = scan_tick AND phase == 3.
- Transfer rule:
  - A transfer happens only in a frame_tick cycle.
  - srcN_ready is combinational: frame_tick AND srcN_valid AND srcN is the arbitration winner.
  - At most one ready is high per cycle. Transfer = valid AND ready.
- Capture:
  - On transfer, register the winner's number and colon mode, set owner = winner, owner_valid = 1, hold_cnt = HOLD_FRAMES.
  - The new number is visible from the next cycle.
- Hold counter:
  - On every frame_tick with no transfer, hold_cnt decrements if it is nonzero.
  - A transfer in the same cycle overrides the decrement and reloads the counter.
- Eligibility at a frame_tick:
  - If owner_valid and hold_cnt > 1, only owner is eligible (owner updates are always allowed and reload hold).
  - Otherwise both sources are eligible.
- Arbitration among eligible valid sources:
  - A single valid source wins.
  - If both are valid, the source equal to the RR pointer wins.
  - After any transfer, the pointer is set to the non-winner.
- Net effect: the other source can take the display no earlier than HOLD_FRAMES complete frames after a grant.
- No valid at a frame_tick: no transfer; number, colon mode and owner are retained indefinitely.
- Valid outside a frame_tick: ignored; ready stays 0. Sources hold valid and data until ready.
- Colon blink:
  - blink_cnt counts frame_ticks 0..BLINK_FRAMES-1.
  - On wrap, the blink phase toggles.
  - The counter runs free, independent of grants.
- colon_en is registered: mode 01 -> 1; mode 10 -> blink phase; 00/11 -> 0.

Test Plan:
(All scenarios use SCAN_DIV=4, HOLD_FRAMES=2, BLINK_FRAMES=2.)
- Timing: release reset, no valids -> scan_tick at cycles 4,8,12,...; frame_tick at 16,32,...; number stays 0x0000; all readies 0.
- Single source: assert src0_valid with 0x1234, colon 01, at cycle 5 -> src0_ready only at cycle 16; number = 0x1234 and colon_en = 1 from cycle 17; owner 0, owner_valid 1.
- Contention and hold: both valid at frame F (src0 = 0x1111, src1 = 0x2222), pointer 0 -> src0 wins at F. At F+1, src1 is not readied and hold goes to 1. At F+2, src1_ready is high and number = 0x2222 next cycle.
- Owner update during hold: after src1's grant, src1 changes to 0xBEEF while src0 stays valid -> src1 is re-granted at the next frame with the hold reloaded; src0 is blocked for that frame and the next, and wins after that.
- Blink: colon mode 10 -> colon_en toggles every 2 frames (32 cycles), phase aligned to frame_tick + 1.
- Async reset: assert rst_n low mid-hold between clock edges -> number, owner_valid, colon_en and readies drop to 0 immediately. After release, timing restarts exactly as in the first scenario.
